// File: rtl/mulalu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// FUNC codes come from defines.vh when it is included first; otherwise local fallbacks apply.
`ifndef FUNC_MUL
`define FUNC_MUL 5'b11000
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b11010
`endif

package mulalu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam int unsigned ITERATIONS = 32;
   localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
   localparam logic [4:0]  FUNC_MUL_C = `FUNC_MUL;
   localparam logic [4:0]  FUNC_DIV_C = `FUNC_DIV;

endpackage

// File: rtl/mulalu_step.sv
// One combinational iteration: MSB-first shift-add multiply or restoring shift-subtract divide.
module mulalu_step #(
   parameter int unsigned W = 32
) (
   input  logic         op_div_i,
   input  logic [W-1:0] hi_i,
   input  logic [W-1:0] lo_i,
   input  logic [W-1:0] mplier_i,
   input  logic [W-1:0] opnd_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] mplier_o
);

   logic [2*W-1:0] prod;
   logic [W:0]     trial;
   logic [W:0]     diff;

   always_comb begin
      hi_o     = hi_i;
      lo_o     = lo_i;
      mplier_o = mplier_i;
      prod     = '0;
      trial    = '0;
      diff     = '0;
      if (op_div_i) begin
         // hi holds the partial remainder, lo shifts the dividend out and the quotient in
         trial = {hi_i, lo_i[W-1]};
         diff  = trial - {1'b0, opnd_i};
         if (!diff[W]) begin
            hi_o = diff[W-1:0];
            lo_o = {lo_i[W-2:0], 1'b1};
         end else begin
            hi_o = trial[W-1:0];
            lo_o = {lo_i[W-2:0], 1'b0};
         end
      end else begin
         prod = ({hi_i, lo_i} << 1) + (mplier_i[W-1] ? {{W{1'b0}}, opnd_i} : {(2*W){1'b0}});
         hi_o     = prod[2*W-1:W];
         lo_o     = prod[W-1:0];
         mplier_o = {mplier_i[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mulalu.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; stalls the pipe for 33 cycles,
// then presents a hi/lo write held while the pipeline is stalled elsewhere.
module mulalu
   import mulalu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = ITERATIONS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mulalu_sign,
   input  logic [4:0]            mulalu_func,
   input  logic [DATA_WIDTH-1:0] source_a,
   input  logic [DATA_WIDTH-1:0] source_b,
   input  logic                  pipe_stall,
   input  logic                  flush,
   output logic                  stall,
   output logic                  hi_write,
   output logic [DATA_WIDTH-1:0] hi_write_data,
   output logic                  lo_write,
   output logic [DATA_WIDTH-1:0] lo_write_data
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           op_div_q, op_div_d;
   logic           sgn_q, sgn_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic           rel_q;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [W-1:0]   a_raw_q, a_raw_d;
   logic [W-1:0]   hi_res_q, hi_res_d;
   logic [W-1:0]   lo_res_q, lo_res_d;

   logic [W-1:0]   step_hi, step_lo, step_mplier;
   logic [W-1:0]   abs_a, abs_b;
   logic [2*W-1:0] prod_fix;
   logic           start, neg_res;

   mulalu_step #(.W(W)) u_step (
      .op_div_i (op_div_q),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .mplier_i (mplier_q),
      .opnd_i   (opnd_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo),
      .mplier_o (step_mplier)
   );

   // rel_q masks a start during reset and the first cycle after release
   assign start   = (mulalu_func != 5'd0) & ~flush & ~rel_q;
   assign abs_a   = (mulalu_sign & source_a[W-1]) ? -source_a : source_a;
   assign abs_b   = (mulalu_sign & source_b[W-1]) ? -source_b : source_b;
   assign neg_res = sgn_q & (sa_q ^ sb_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      sgn_d    = sgn_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mplier_d = mplier_q;
      opnd_d   = opnd_q;
      a_raw_d  = a_raw_q;
      hi_res_d = hi_res_q;
      lo_res_d = lo_res_q;
      prod_fix = '0;
      stall    = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               stall    = 1'b1;
               state_d  = BUSY;
               cnt_d    = '0;
               op_div_d = (mulalu_func == FUNC_DIV_C);
               sgn_d    = mulalu_sign;
               sa_d     = mulalu_sign & source_a[W-1];
               sb_d     = mulalu_sign & source_b[W-1];
               a_raw_d  = source_a;
               hi_d     = '0;
               if (mulalu_func == FUNC_DIV_C) begin
                  lo_d     = abs_a;
                  opnd_d   = abs_b;
                  mplier_d = '0;
               end else begin
                  lo_d     = '0;
                  opnd_d   = abs_a;
                  mplier_d = abs_b;
               end
            end
         end
         BUSY: begin
            stall    = 1'b1;
            hi_d     = step_hi;
            lo_d     = step_lo;
            mplier_d = step_mplier;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
               // Final iteration result goes straight to the result registers with sign fix-up
               if (!op_div_q) begin
                  prod_fix = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
                  hi_res_d = prod_fix[2*W-1:W];
                  lo_res_d = prod_fix[W-1:0];
               end else if (opnd_q == '0) begin
                  hi_res_d = a_raw_q;
                  lo_res_d = W'(DIV0_QUOT);
               end else begin
                  lo_res_d = neg_res ? -step_lo : step_lo;
                  hi_res_d = (sgn_q & sa_q) ? -step_hi : step_hi;
               end
            end
         end
         DONE: begin
            hi_write = 1'b1;
            lo_write = 1'b1;
            if (!pipe_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         stall    = 1'b0;
         hi_write = 1'b0;
         lo_write = 1'b0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rel_q <= 1'b1;
      else     rel_q <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         sgn_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mplier_q <= '0;
         opnd_q   <= '0;
         a_raw_q  <= '0;
         hi_res_q <= '0;
         lo_res_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_div_q <= op_div_d;
         sgn_q    <= sgn_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mplier_q <= mplier_d;
         opnd_q   <= opnd_d;
         a_raw_q  <= a_raw_d;
         hi_res_q <= hi_res_d;
         lo_res_q <= lo_res_d;
      end
   end

   assign hi_write_data = hi_res_q;
   assign lo_write_data = lo_res_q;

endmodule

// File: tb/tb_mulalu.sv
// Self-checking bench for mulalu: arithmetic reference model plus directed literal checks.
module tb_mulalu;
   import mulalu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mulalu_sign = 1'b0;
   logic [4:0]  mulalu_func = 5'd0;
   logic [31:0] source_a = '0;
   logic [31:0] source_b = '0;
   logic        pipe_stall = 1'b0;
   logic        flush = 1'b0;
   logic        stall, hi_write, lo_write;
   logic [31:0] hi_write_data, lo_write_data;

   int n_cmp = 0;
   int n_err = 0;

   mulalu #(.DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mulalu_sign   (mulalu_sign),
      .mulalu_func   (mulalu_func),
      .source_a      (source_a),
      .source_b      (source_b),
      .pipe_stall    (pipe_stall),
      .flush         (flush),
      .stall         (stall),
      .hi_write      (hi_write),
      .hi_write_data (hi_write_data),
      .lo_write      (lo_write),
      .lo_write_data (lo_write_data)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_result(input logic s, input logic [4:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = s ? longint'($signed(a)) : longint'({32'b0, a});
      sb = s ? longint'($signed(b)) : longint'({32'b0, b});
      if (f != FUNC_DIV_C) begin
         if (s) p = 64'(sa * sb);
         else   p = {32'b0, a} * {32'b0, b};
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      if (s) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
   endfunction

   // Model: m_cnt = 0 idle, 1..32 iterating, 33 writing result
   int          m_cnt = 0;
   logic        m_rel = 1'b1;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0;
         m_rel = 1'b1;
      end else begin
         if (flush) m_cnt = 0;
         else if (m_cnt == 0) begin
            if (mulalu_func != 5'd0 && !m_rel) begin
               m_cnt = 1;
               {m_hi, m_lo} = ref_result(mulalu_sign, mulalu_func, source_a, source_b);
            end
         end else if (m_cnt <= 32) m_cnt++;
         else if (!pipe_stall) m_cnt = 0;
         m_rel = 1'b0;
      end
   end

   logic e_stall, e_wr;
   always @(negedge clk) begin
      if (rst) begin
         e_stall = 1'b0;
         e_wr    = 1'b0;
      end else begin
         e_wr    = (m_cnt == 33) && !flush;
         e_stall = !flush && ((m_cnt >= 1 && m_cnt <= 32) ||
                              (m_cnt == 0 && mulalu_func != 5'd0 && !m_rel));
      end
      n_cmp++;
      if (stall !== e_stall) begin
         n_err++;
         $display("FAIL model_stall t=%0t: got %b expected %b", $time, stall, e_stall);
      end
      n_cmp++;
      if (hi_write !== e_wr || lo_write !== e_wr) begin
         n_err++;
         $display("FAIL model_write t=%0t: got hi=%b lo=%b expected %b", $time, hi_write, lo_write, e_wr);
      end
      if (e_wr) begin
         n_cmp++;
         if (hi_write_data !== m_hi || lo_write_data !== m_lo) begin
            n_err++;
            $display("FAIL model_data t=%0t: got %h_%h expected %h_%h", $time,
                     hi_write_data, lo_write_data, m_hi, m_lo);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one op, emulate the EX stage holding it until it advances, and collect results.
   task automatic run_op(input string nm, input logic s, input logic dv,
                         input logic [31:0] a, input logic [31:0] b, input int ps,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_wr);
      int stalls, writes;
      logic [31:0] hi, lo;
      logic ps_now, done;
      stalls = 0; writes = 0; hi = '0; lo = '0; done = 1'b0;
      @(posedge clk); #1;
      mulalu_sign = s;
      mulalu_func = dv ? FUNC_DIV_C : FUNC_MUL_C;
      source_a = a;
      source_b = b;
      pipe_stall = (ps > 0);
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (hi_write) begin
            writes++;
            hi = hi_write_data;
            lo = lo_write_data;
         end
         ps_now = pipe_stall;
         @(posedge clk); #1;
         if (writes > 0) begin
            if (!ps_now) begin
               mulalu_func = 5'd0;
               done = 1'b1;
            end else if (writes >= ps) pipe_stall = 1'b0;
         end
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no completion expected completion within 100 cycles", nm);
         mulalu_func = 5'd0;
         pipe_stall = 1'b0;
      end
      chk({nm, "_stalls"}, 64'(stalls), 64'd33);
      chk({nm, "_writes"}, 64'(writes), 64'(exp_wr));
      chk({nm, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
      chk({nm, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {61'b0, stall, hi_write, lo_write}, 64'd0);
      chk("rst_data", {hi_write_data, lo_write_data}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_outputs", {61'b0, stall, hi_write, lo_write}, 64'd0);

      run_op("smul_m3x5",   1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5,         0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
      run_op("umul_max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1);
      run_op("sdiv_m7d2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
      run_op("sdiv_7dm2",   1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD, 1);
      run_op("udiv_100d7",  1'b0, 1'b1, 32'd100,       32'd7,         0, 32'd2,         32'd14,        1);
      run_op("udiv_zero",   1'b0, 1'b1, 32'd1234,      32'd0,         0, 32'd1234,      32'hFFFF_FFFF, 1);
      run_op("sdiv_zero",   1'b1, 1'b1, 32'hFFFF_FF00, 32'd0,         0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1);
      run_op("sdiv_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         32'h8000_0000, 1);
      run_op("smul_pstall", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7,         3, 32'hFFFF_FFFF, 32'hFFFF_FD44, 4);
      @(negedge clk);
      chk("no_restart", {62'b0, stall, hi_write}, 64'd0);

      // flush in BUSY iteration 10
      @(posedge clk); #1;
      mulalu_sign = 1'b0; mulalu_func = FUNC_MUL_C; source_a = 32'd3; source_b = 32'd4;
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_busy", {61'b0, stall, hi_write, lo_write}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; mulalu_func = 5'd0;
      @(negedge clk);
      chk("flush_idle", {61'b0, stall, hi_write, lo_write}, 64'd0);
      run_op("umul_after_flush", 1'b0, 1'b0, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1);

      // flush together with a start
      @(posedge clk); #1;
      mulalu_func = FUNC_DIV_C; flush = 1'b1;
      @(negedge clk);
      chk("flush_start", {63'b0, stall}, 64'd0);
      @(posedge clk); #1;
      mulalu_func = 5'd0; flush = 1'b0;
      @(negedge clk);
      chk("flush_nostart", {63'b0, stall}, 64'd0);

      // reset in the middle of an operation
      @(posedge clk); #1;
      mulalu_sign = 1'b1; mulalu_func = FUNC_DIV_C;
      source_a = 32'hFFFF_FF9C; source_b = 32'd7;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      mulalu_func = 5'd0;
      #1;
      chk("rst_mid_outputs", {61'b0, stall, hi_write, lo_write}, 64'd0);
      chk("rst_mid_data", {hi_write_data, lo_write_data}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_op("sdiv_after_rst", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mulalu.md
Name: mulalu

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU.
- Consumes that ALU's mulalu_sign and mulalu_func, plus the same source_a and source_b operands.
- Computes MULT/MULTU/DIV/DIVU over 32 iteration cycles and stalls the pipeline while running.
- Produces hi/lo write requests; the EX stage merges these with MTHI/MTLO.

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH. Only 32 is verified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mulalu_sign  in  1  1 = signed operation, 0 = unsigned.
- mulalu_func  in  5  `FUNC_MUL or `FUNC_DIV starts an operation; 5'b00000 means no operation.
- source_a  in  DATA_WIDTH  multiplicand/dividend.
- source_b  in  DATA_WIDTH  multiplier/divisor.
- pipe_stall  in  1  pipeline held by another source; EX does not advance this cycle.
- flush  in  1  exception/flush; abort the current operation.
- stall  out  1  unit busy; hold IF..EX.
- hi_write  out  1  write hi this cycle.
- hi_write_data  out  DATA_WIDTH  product[63:32] or remainder.
- lo_write  out  1  write lo this cycle.
- lo_write_data  out  DATA_WIDTH  product[31:0] or quotient.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset, asynchronous, at any time including mid-operation:
  - state goes to IDLE; counter, accumulators and latched operands clear to 0.
  - All outputs are 0 while rst is high and on the first cycle after release.
- IDLE:
  - If mulalu_func != 0 and flush == 0, latch the following, clear the counter and go to BUSY:
    - |source_a| and |source_b| when signed, raw values when unsigned;
    - the sign of each operand, op type and signedness.
  - stall = (mulalu_func != 0) & ~flush, combinational in the start cycle.
- BUSY:
  - One iteration per cycle; counter runs 0..31. When counter == 31, go to DONE.
  - stall = 1 throughout.
- Multiply iteration: 64-bit shift-add on unsigned magnitudes.
- Divide iteration: restoring shift-subtract on unsigned magnitudes, producing a 32-bit quotient and remainder.
- DONE:
  - stall = 0, hi_write = lo_write = 1, with final data driven from registers.
  - Stay in DONE while pipe_stall == 1; repeating the identical write is idempotent.
  - Go to IDLE on the first cycle with pipe_stall == 0.
  - The same instruction therefore never restarts.
- Latency: start cycle + 32 BUSY cycles. stall is high for exactly 33 cycles and the write occurs in cycle 34.
- Sign fix-up, applied when entering DONE for signed operations:
  - product is negated if sign_a ^ sign_b;
  - quotient is negated if sign_a ^ sign_b;
  - remainder takes the sign of the dividend.
- Divide by zero (source_b == 0, either signedness):
  - lo = 32'hFFFF_FFFF, hi = source_a as originally presented;
  - no exception, same latency.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0 (natural wrap, no trap).
- Outputs hi_write_data/lo_write_data are registered and hold their last value outside DONE; they are valid only when the write signal is 1.
- flush in any state:
  - stall, hi_write and lo_write are forced to 0 combinationally in that cycle;
  - state goes to IDLE next edge, and the partial result is discarded.
- flush together with a start in IDLE: no start.
- hi/lo are never written by this block outside DONE.

Decomposition:
- Shared package mulalu_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the iteration-count constant;
  - the divide-by-zero quotient constant 32'hFFFF_FFFF.
- FUNC codes remain in defines.vh.
- One natural sub-module: mulalu_step, a combinational single iteration selected by op:
  - multiply: shift-add, taking (acc64, multiplier) and returning the next values;
  - divide: restore-subtract, taking (rem, quot, divisor) and returning the next values.

Test Plan:
- Signed MUL, a = 32'hFFFF_FFFD (-3), b = 5 -> stall high for 33 cycles, then one write with hi = FFFF_FFFF, lo = FFFF_FFF1.
- Unsigned MUL, FFFF_FFFF * FFFF_FFFF -> hi = FFFF_FFFE, lo = 0000_0001.
- Signed DIV, -7 / 2 -> lo = FFFF_FFFD, hi = FFFF_FFFF.
- Unsigned DIV, 100 / 7 -> lo = 14, hi = 2.
- DIV by zero, a = 1234 -> lo = FFFF_FFFF, hi = 1234.
- Signed DIV, 8000_0000 / FFFF_FFFF -> lo = 8000_0000, hi = 0.
- Signed MUL with pipe_stall held for 3 cycles on reaching DONE -> writes stay high for 4 cycles with constant data, then IDLE with no restart.
- flush asserted at BUSY cycle 10 -> stall = 0 that cycle, no write, IDLE next cycle; a following MUL produces correct results.
- rst asserted mid-BUSY -> outputs 0 immediately; after release, a new DIV completes with correct results.
